ibex_bcp_region_ctrl: RTL
=========================

// Module: ibex_bcp_region_ctrl
// PURPOSE
//  Owns the BCP region-bound table that feeds csr_bcp_addr_i of the bound checker.
//  CSR writes arrive as start/end word pairs. Start is staged; end commits both words atomically.
//  Commit happens only after validation, and only once the checker has no check in flight.
//  Optional sticky per-pair lock. Sits between the CSR file and the bound-check unit in EX.
// PARAMETERS
//  BCPNumRegions  4    number of table words; even, >=4; pair p = words {2p, 2p+1}
//  QuiesceTimeout 15   max cycles to wait for bcp_check_active_i low before abort; 1..255
// PORTS
//  clk_i              in   1        clock
//  rst_ni             in   1        async active-low reset
//  csr_bcp_we_i       in   1        write request; held with idx/wdata stable until ack_o
//  csr_bcp_idx_i      in   IW       word index, IW=$clog2(BCPNumRegions)
//  csr_bcp_wdata_i    in   32       {tag[31:24], addr[23:0]}
//  csr_bcp_ack_o      out  1        registered 1-cycle pulse: request completed
//  csr_bcp_err_o      out  1        valid only with ack_o: request rejected, table unchanged
//  csr_bcp_busy_o     out  1        high in STAGED or QUIESCE
//  csr_bcp_rdata_o    out  32       committed word at csr_bcp_idx_i (combinational; staged data never visible)
//  csr_bcp_lock_we_i  in   1        set lock for pair csr_bcp_idx_i[IW-1:1]
//  csr_bcp_lock_o     out  N/2      per-pair lock bits
//  bcp_check_active_i in   1        bound checker has a LOAD/STORE/INCP/SETAG check in EX
//  csr_bcp_addr_o     out  32xN     committed table to the checker
// BEHAVIOUR
//  Reset: table=0, lock=0, state=IDLE, ack/err=0, timeout counter=0. Staged data is discarded.
//  Request sampling: we_i is sampled only when ack_o==0, so a held request is not re-taken in its ack cycle.
//  IDLE:
//    - even idx: stage wdata, record pair. Ack next cycle, err=0. Go to STAGED.
//    - odd idx: ack with err=1. Stay in IDLE.
//  STAGED:
//    - even idx: overwrite stage (new pair allowed), ack, err=0.
//    - odd idx == 2*staged_pair+1: capture end word, clear counter, go to QUIESCE. No ack yet.
//    - odd idx of another pair: ack with err=1. Stage kept.
//  QUIESCE:
//    - each cycle bcp_check_active_i==1: counter++.
//    - counter==QuiesceTimeout: ack with err=1, discard, go to IDLE.
//    - bcp_check_active_i==0: validate and decide at that edge.
//        valid = start.addr<=end.addr (24b unsigned) && start.tag==end.tag
//                && start.tag!=8'h00 && start.tag!=8'hFF.
//        valid: both words written to table; ack=1 err=0 in the following cycle; table update visible on the same edge ack rises.
//        invalid: ack with err=1, table unchanged.
//      Either way, go to IDLE.
//  Latency:
//    - even write: ack 1 cycle after we_i.
//    - end write: ack >=2 cycles after we_i; exactly 2 if check_active is low.
//  Ack overlap: at most one ack per request; ack and err never assert without a request.
//  Lock write: takes effect next edge; may coincide with any state. If it hits the pair currently staged, that commit fails with err=1.
//  Simultaneous we_i and lock_we_i to same pair: lock wins, write gets err=1.
//  Reset mid-QUIESCE: no commit, no ack.
// CONFIGURATION
//  IBEX_BCP_LOCK_EN defined:
//    - lock bits sticky until reset.
//    - any write (even or odd) to a locked pair: ack with err=1 in the next cycle. State unchanged, except that in QUIESCE the commit is aborted with err.
//  IBEX_BCP_LOCK_EN undefined:
//    - lock_o tied to 0; lock_we_i ignored.
//    - all writes subject only to validation rules above.
// TESTING
//  1 Write idx0=0x4A001000, then idx1=0x4A0010FF, check_active=0
//    -> acks at +1 and +2 cycles, err=0; addr_o[0..1] updated; rdata matches.
//  2 Write idx1=0x4A0010FF from IDLE
//    -> ack, err=1; table remains 0; state IDLE.
//  3 Stage idx2=0x55002000 / idx3=0x55001000 (start>end)
//    -> ack err=1; addr_o[2..3] unchanged.
//  4 Same pair with tags 0x55/0x56
//    -> err=1. Start tag 0xFF -> err=1.
//  5 Valid pair, check_active held 1 for 20 cycles (QuiesceTimeout=15)
//    -> ack err=1 at cycle 16, no update.
//    Same test, drop check_active at cycle 5 -> commit and ack at cycle 6.
//  6 LOCK_EN: lock pair 0, then write idx0
//    -> ack err=1. Lock pair 1 while QUIESCE on pair 1 -> err=1.
//    Reset -> lock_o=0, table=0.

Source files
------------

// File: rtl/ibex_bcp_region_ctrl.sv
// BCP region-bound table: stages start/end CSR word pairs, validates them and commits atomically once the bound checker is idle.
// Even write acks next cycle; end write acks >=2 cycles after the request (quiesce-bounded); optional sticky per-pair lock via IBEX_BCP_LOCK_EN.
module ibex_bcp_region_ctrl #(
  parameter int unsigned BCPNumRegions  = 4,
  parameter int unsigned QuiesceTimeout = 15
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                csr_bcp_we_i,
  input  logic [$clog2(BCPNumRegions)-1:0]    csr_bcp_idx_i,
  input  logic [31:0]                         csr_bcp_wdata_i,
  output logic                                csr_bcp_ack_o,
  output logic                                csr_bcp_err_o,
  output logic                                csr_bcp_busy_o,
  output logic [31:0]                         csr_bcp_rdata_o,
  input  logic                                csr_bcp_lock_we_i,
  output logic [BCPNumRegions/2-1:0]          csr_bcp_lock_o,
  input  logic                                bcp_check_active_i,
  output logic [BCPNumRegions-1:0][31:0]      csr_bcp_addr_o
);

  localparam int unsigned IW = $clog2(BCPNumRegions);
  localparam int unsigned NP = BCPNumRegions / 2;
  localparam int unsigned PW = IW - 1;

  typedef enum logic [1:0] {
    Idle,
    Staged,
    Quiesce
  } state_e;

  state_e                  state_q, state_d;
  logic [NP-1:0][1:0][31:0] table_q;
  logic [31:0]             start_q, end_q;
  logic [PW-1:0]           pair_q;
  logic [7:0]              cnt_q;
  logic                    ack_q, err_q;

  logic                    ack_d, err_d;
  logic                    stage_ld, end_ld, commit, cnt_inc;
  logic                    req, req_odd;
  logic [PW-1:0]           req_pair;
  logic                    req_locked, stage_locked;
  logic                    timeout, pair_valid;

  // A request still held high during its own ack cycle must not be taken twice.
  assign req      = csr_bcp_we_i & ~ack_q;
  assign req_pair = csr_bcp_idx_i[IW-1:1];
  assign req_odd  = csr_bcp_idx_i[0];
  assign timeout  = (cnt_q == 8'(QuiesceTimeout));

  assign pair_valid = (start_q[23:0] <= end_q[23:0]) &&
                      (start_q[31:24] == end_q[31:24]) &&
                      (start_q[31:24] != 8'h00) &&
                      (start_q[31:24] != 8'hFF);

`ifdef IBEX_BCP_LOCK_EN
  logic [NP-1:0] lock_q;

  // Lock and write share the index, so a same-cycle lock always targets the written pair.
  assign req_locked   = lock_q[req_pair] | csr_bcp_lock_we_i;
  assign stage_locked = lock_q[pair_q] | (csr_bcp_lock_we_i & (req_pair == pair_q));
  assign csr_bcp_lock_o = lock_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= '0;
    end else if (csr_bcp_lock_we_i) begin
      lock_q[req_pair] <= 1'b1;
    end
  end
`else
  logic unused_lock_we;

  assign unused_lock_we = csr_bcp_lock_we_i;
  assign req_locked     = 1'b0;
  assign stage_locked   = 1'b0;
  assign csr_bcp_lock_o = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Idle: begin
        if (req && !req_locked && !req_odd) state_d = Staged;
      end
      Staged: begin
        if (req && !req_locked && req_odd && (req_pair == pair_q)) state_d = Quiesce;
      end
      Quiesce: begin
        if (stage_locked || timeout || !bcp_check_active_i) state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  always_comb begin
    ack_d    = 1'b0;
    err_d    = 1'b0;
    stage_ld = 1'b0;
    end_ld   = 1'b0;
    commit   = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state_q)
      Idle: begin
        if (req) begin
          ack_d    = 1'b1;
          err_d    = req_locked | req_odd;
          stage_ld = ~req_locked & ~req_odd;
        end
      end
      Staged: begin
        if (req) begin
          if (req_locked) begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end else if (!req_odd) begin
            ack_d    = 1'b1;
            stage_ld = 1'b1;
          end else if (req_pair == pair_q) begin
            end_ld = 1'b1;
          end else begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end
        end
      end
      Quiesce: begin
        // Lock and timeout abort ahead of the commit decision.
        if (stage_locked || timeout) begin
          ack_d = 1'b1;
          err_d = 1'b1;
        end else if (!bcp_check_active_i) begin
          ack_d  = 1'b1;
          err_d  = ~pair_valid;
          commit = pair_valid;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q <= '0;
      end_q   <= '0;
      pair_q  <= '0;
      cnt_q   <= '0;
      table_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      if (stage_ld) begin
        start_q <= csr_bcp_wdata_i;
        pair_q  <= req_pair;
      end
      if (end_ld) begin
        end_q <= csr_bcp_wdata_i;
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (commit) begin
        table_q[pair_q][0] <= start_q;
        table_q[pair_q][1] <= end_q;
      end
    end
  end

  assign csr_bcp_ack_o   = ack_q;
  assign csr_bcp_err_o   = err_q;
  assign csr_bcp_busy_o  = (state_q == Staged) || (state_q == Quiesce);
  assign csr_bcp_rdata_o = table_q[req_pair][req_odd];
  assign csr_bcp_addr_o  = table_q;

endmodule
